// File: rtl/tick_mod_counter.sv
// rtl/tick_mod_counter.sv - modulo-MOD up/down counter stepped by an integrated clock-enable divider
//
// Purpose:
//   Single-clock modulo counter. A divider issues a step enable every `num`
//   cycles (num of 0 or 1 means every cycle). On a step the counter moves one
//   position up or down, wrapping inside 0..MOD-1; the wrap raises `carry`.
//   A synchronous load, clamped to MOD-1, overrides any step and restarts the
//   divider phase.
//
// Configuration macro:
//   TICK_CNT_CASCADE_EN - adds input `cin`, which gates the step so stages can
//                         be chained (next stage cin = previous stage carry).
//                         When undefined, cin is the constant 1 internally.
//
// Ports:
//   clk       in   1      system clock, rising edge
//   rst       in   1      asynchronous reset, active-high
//   num       in   DIV_W  clk cycles per count step
//   en        in   1      1 = divider runs and counter may step, 0 = freeze
//   up        in   1      count direction, sampled on step cycles
//   load      in   1      synchronous load strobe
//   load_val  in   CNT_W  load value (clamped to MOD-1)
//   cin       in   1      cascade step gate (TICK_CNT_CASCADE_EN only)
//   out       out  CNT_W  registered counter value
//   tick      out  1      pulse in the cycle out shows a stepped value
//   carry     out  1      pulse on wrap, only ever high together with tick

module tick_mod_counter #(
  parameter int CNT_W = 6,
  parameter int MOD   = 60,
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] num,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
`ifdef TICK_CNT_CASCADE_EN
  input  logic             cin,
`endif
  output logic [CNT_W-1:0] out,
  output logic             tick,
  output logic             carry
);

  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MOD - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic             tick_q, tick_d;
  logic             carry_q, carry_d;

  logic [DIV_W-1:0] lim;
  logic             period_done;
  logic             step;
  logic             cin_int;

`ifdef TICK_CNT_CASCADE_EN
  assign cin_int = cin;
`else
  assign cin_int = 1'b1;
`endif

  // num of 0 and 1 both collapse to a limit of 0, i.e. a step every cycle.
  // num is compared live, so lowering it below div_cnt fires on the next edge.
  assign lim         = (num <= DIV_W'(1)) ? '0 : num - DIV_W'(1);
  assign period_done = (div_cnt_q >= lim);
  assign step        = en & period_done & cin_int;

  // Divider: the period boundary clears the count even when cin holds the step
  // off, so a cascaded stage keeps its phase aligned with the stage below.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (load) begin
      div_cnt_d = '0;
    end else if (en) begin
      div_cnt_d = period_done ? '0 : div_cnt_q + DIV_W'(1);
    end
  end

  // Counter: load beats step beats hold.
  always_comb begin
    out_d   = out_q;
    tick_d  = 1'b0;
    carry_d = 1'b0;
    if (load) begin
      out_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (step) begin
      tick_d = 1'b1;
      if (up) begin
        carry_d = (out_q == MAX_VAL);
        out_d   = (out_q == MAX_VAL) ? '0 : out_q + CNT_W'(1);
      end else begin
        carry_d = (out_q == '0);
        out_d   = (out_q == '0) ? MAX_VAL : out_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      out_q     <= '0;
      tick_q    <= 1'b0;
      carry_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      out_q     <= out_d;
      tick_q    <= tick_d;
      carry_q   <= carry_d;
    end
  end

  assign out   = out_q;
  assign tick  = tick_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_tick_mod_counter.sv
// tb/tb_tick_mod_counter.sv - directed scoreboard bench for tick_mod_counter

module tb_tick_mod_counter;

  localparam int CNT_W = 6;
  localparam int MOD   = 60;
  localparam int DIV_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [DIV_W-1:0] num;
  logic             en;
  logic             up;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] out;
  logic             tick;
  logic             carry;

  always #5 clk = ~clk;

  tick_mod_counter #(.CNT_W(CNT_W), .MOD(MOD), .DIV_W(DIV_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .num      (num),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
`ifdef TICK_CNT_CASCADE_EN
    .cin      (1'b1),
`endif
    .out      (out),
    .tick     (tick),
    .carry    (carry)
  );

  typedef struct {
    int out;
    int tick;
    int carry;
  } exp_t;

  exp_t  sb[$];
  int    errors = 0;
  int    checks = 0;
  string phase  = "reset";

  // Reference model state
  int m_out   = 0;
  int m_div   = 0;
  int m_tick  = 0;
  int m_carry = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s/%s: observed=%0d expected=%0d", phase, tag, obs, exp);
    end
  endtask

  task automatic compare_pop();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s/scoreboard: observed=empty expected=entry", phase);
    end else begin
      e = sb.pop_front();
      check_val("out",   32'(out),   32'(e.out));
      check_val("tick",  32'(tick),  32'(e.tick));
      check_val("carry", 32'(carry), 32'(e.carry));
    end
  endtask

  task automatic push_model();
    exp_t e;
    e.out   = m_out;
    e.tick  = m_tick;
    e.carry = m_carry;
    sb.push_back(e);
  endtask

  // Advance the model by one edge from the currently driven inputs, push the
  // expectation, let the DUT take the edge, then compare.
  task automatic cycle();
    int lim;
    bit due;
    lim = (num <= 1) ? 0 : int'(num) - 1;
    due = en && (m_div >= lim);
    if (load) begin
      m_out   = (int'(load_val) > MOD - 1) ? MOD - 1 : int'(load_val);
      m_div   = 0;
      m_tick  = 0;
      m_carry = 0;
    end else if (due) begin
      m_tick = 1;
      m_div  = 0;
      if (up) begin
        m_carry = (m_out == MOD - 1) ? 1 : 0;
        m_out   = (m_out == MOD - 1) ? 0 : m_out + 1;
      end else begin
        m_carry = (m_out == 0) ? 1 : 0;
        m_out   = (m_out == 0) ? MOD - 1 : m_out - 1;
      end
    end else begin
      m_tick  = 0;
      m_carry = 0;
      if (en) m_div = m_div + 1;
    end
    push_model();
    @(posedge clk);
    #1;
    compare_pop();
  endtask

  task automatic model_reset();
    m_out   = 0;
    m_div   = 0;
    m_tick  = 0;
    m_carry = 0;
  endtask

  initial begin
    rst      = 1'b1;
    num      = 32'd4;
    en       = 1'b0;
    up       = 1'b1;
    load     = 1'b0;
    load_val = '0;

    // Reset state, held across edges
    #1;
    model_reset();
    push_model();
    compare_pop();
    @(posedge clk);
    @(posedge clk);
    #1;
    push_model();
    compare_pop();
    rst = 1'b0;

    // 1: free-run up with num=4 through a full wrap
    phase = "freerun";
    en = 1'b1;
    up = 1'b1;
    for (int i = 0; i < 4 * 61 + 2; i++) cycle();

    // 2: load 0 then count down every cycle; borrow wraps to 59
    phase = "down";
    load = 1'b1;
    load_val = 6'd0;
    cycle();
    load = 1'b0;
    up = 1'b0;
    num = 32'd1;
    for (int i = 0; i < 64; i++) cycle();
    phase = "num0";
    num = 32'd0;
    for (int i = 0; i < 4; i++) cycle();

    // 3: clamped load on a cycle where the step is due
    phase = "loadclamp";
    up = 1'b1;
    num = 32'd4;
    load = 1'b1;
    load_val = 6'd10;
    cycle();
    load = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    load = 1'b1;
    load_val = 6'd63;
    cycle();
    load = 1'b0;
    for (int i = 0; i < 9; i++) cycle();
    phase = "loadnoen";
    en = 1'b0;
    load = 1'b1;
    load_val = 6'd60;
    cycle();
    load = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 5; i++) cycle();

    // 4: freeze mid-period, then shrink num below the current phase
    phase = "enable";
    num = 32'd100;
    load = 1'b1;
    load_val = 6'd20;
    cycle();
    load = 1'b0;
    for (int i = 0; i < 50; i++) cycle();
    en = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    en = 1'b1;
    phase = "numdrop";
    num = 32'd3;
    cycle();
    for (int i = 0; i < 7; i++) cycle();

    // 5: async reset between edges while tick/carry are high
    phase = "async";
    num = 32'd1;
    up = 1'b1;
    load = 1'b1;
    load_val = 6'd59;
    cycle();
    load = 1'b0;
    cycle();
    num = 32'd4;
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    push_model();
    compare_pop();
    #1;
    rst = 1'b0;
    for (int i = 0; i < 9; i++) cycle();

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL end/scoreboard: observed=%0d leftover expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
